// File: rtl/mipi_tx_pkg.sv
// mipi_tx_pkg: shared FSM states, RAW10 packing constants and pattern-select encodings
// for the CSI-2 TX frame generator and the top level's MIPI_TX1_TYPE drive.
package mipi_tx_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_VS_PRE,
        S_HS_PRE,
        S_ACTIVE,
        S_HS_POST,
        S_LINE_GAP,
        S_VS_POST,
        S_FRAME_GAP
    } state_t;
    localparam int         PIX_PER_BEAT = 6;
    localparam int         PIX_BITS     = 10;
    localparam logic [5:0] RAW10_DT     = 6'h2B;
    localparam logic [1:0] PAT_HRAMP    = 2'd0;
    localparam logic [1:0] PAT_VRAMP    = 2'd1;
    localparam logic [1:0] PAT_CHECKER  = 2'd2;
    localparam logic [1:0] PAT_CONST    = 2'd3;
endpackage

// File: rtl/mipi_raw10_pattern.sv
// mipi_raw10_pattern: combinational RAW10 test-pattern pixel value for one pixel position.
module mipi_raw10_pattern
    import mipi_tx_pkg::*;
(
    input  logic [PIX_BITS-1:0] i_x,
    input  logic [PIX_BITS-1:0] i_y,
    input  logic [1:0]          i_pat,
    input  logic [PIX_BITS-1:0] i_const,
    output logic [PIX_BITS-1:0] o_pix
);
    // x and y arrive already reduced mod 1024; the 8x8 checker only needs bit 3 of each
    always_comb o_pix = (i_pat == PAT_HRAMP)   ? i_x :
                        (i_pat == PAT_VRAMP)   ? i_y :
                        (i_pat == PAT_CHECKER) ? {PIX_BITS{i_x[3] ^ i_y[3]}} : i_const;
endmodule

// File: rtl/mipi_tx_frame_gen.sv
// mipi_tx_frame_gen: programmable CSI-2 pixel-interface timing and RAW10 test-pattern generator.
// Optional MIPI_FRAME_GEN_FRAME_CNT_EN adds frame_cnt and stamps it into pixel 0 of line 0.
module mipi_tx_frame_gen
    import mipi_tx_pkg::*;
#(
    parameter int H_PIXELS  = 600,
    parameter int V_LINES   = 480,
    parameter int VS_LEAD   = 2,
    parameter int HS_LEAD   = 98,
    parameter int HS_TRAIL  = 100,
    parameter int LINE_GAP  = 16,
    parameter int VS_TRAIL  = 2,
    parameter int FRAME_GAP = 10000
) (
    input  logic        tx_pixel_clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [9:0]  const_pix,
    output logic        vsync,
    output logic        hsync,
    output logic        valid,
    output logic [63:0] data,
    output logic        busy,
    output logic        frame_done
`ifdef MIPI_FRAME_GEN_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);
    localparam logic [15:0] L_VS   = 16'(VS_LEAD - 1);
    localparam logic [15:0] L_HSL  = 16'(HS_LEAD - 1);
    localparam logic [15:0] L_ACT  = 16'(H_PIXELS / PIX_PER_BEAT - 1);
    localparam logic [15:0] L_HST  = 16'(HS_TRAIL - 1);
    localparam logic [15:0] L_LG   = 16'(LINE_GAP - 1);
    localparam logic [15:0] L_VST  = 16'(VS_TRAIL - 1);
    localparam logic [15:0] L_FG   = 16'(FRAME_GAP - 1);
    localparam logic [15:0] L_LINE = 16'(V_LINES - 1);

    state_t                            r_state, w_state;
    logic [15:0]                       r_cnt, r_line, w_cnt_nxt, w_line_nxt;
    logic [1:0]                        r_pat;
    logic [PIX_BITS-1:0]               r_const, w_xb, w_p0;
    logic [PIX_PER_BEAT*PIX_BITS-1:0]  w_beat;
    logic                              w_enter, w_latch, w_fd;
`ifdef MIPI_FRAME_GEN_FRAME_CNT_EN
    logic [15:0]                       r_frame_cnt;
    assign frame_cnt = r_frame_cnt;
`endif

    always_comb begin
        w_state = r_state;
        case (r_state)
            S_IDLE:      w_state = enable ? S_VS_PRE : S_IDLE;
            S_VS_PRE:    if (r_cnt == L_VS)  w_state = S_HS_PRE;
            S_HS_PRE:    if (r_cnt == L_HSL) w_state = S_ACTIVE;
            S_ACTIVE:    if (r_cnt == L_ACT) w_state = S_HS_POST;
            S_HS_POST:   if (r_cnt == L_HST) w_state = S_LINE_GAP;
            S_LINE_GAP:  if (r_cnt == L_LG)  w_state = (r_line == L_LINE) ? S_VS_POST : S_HS_PRE;
            S_VS_POST:   if (r_cnt == L_VST) w_state = S_FRAME_GAP;
            S_FRAME_GAP: if (r_cnt == L_FG)  w_state = enable ? S_VS_PRE : S_IDLE;
            default:     w_state = S_IDLE;
        endcase
    end

    // Counters are computed for the upcoming cycle so the pattern lookup can be registered with it
    assign w_enter    = w_state != r_state;
    assign w_cnt_nxt  = w_enter ? 16'd0 : r_cnt + 16'd1;
    assign w_line_nxt = (w_state == S_VS_PRE) ? 16'd0 :
                        (r_state == S_LINE_GAP && w_state == S_HS_PRE) ? r_line + 16'd1 : r_line;
    assign w_latch    = w_enter && w_state == S_VS_PRE;
    assign w_fd       = w_enter && w_state == S_FRAME_GAP;
    assign w_xb       = PIX_BITS'(w_cnt_nxt * 16'd6);

    for (genvar k = 0; k < PIX_PER_BEAT; k++) begin : g_lane
        mipi_raw10_pattern u_pat (
            .i_x     (w_xb + PIX_BITS'(k)),
            .i_y     (w_line_nxt[PIX_BITS-1:0]),
            .i_pat   (r_pat),
            .i_const (r_const),
            .o_pix   (w_beat[k*PIX_BITS +: PIX_BITS])
        );
    end

`ifdef MIPI_FRAME_GEN_FRAME_CNT_EN
    assign w_p0 = (w_line_nxt == 16'd0 && w_cnt_nxt == 16'd0) ? r_frame_cnt[PIX_BITS-1:0] : w_beat[PIX_BITS-1:0];
`else
    assign w_p0 = w_beat[PIX_BITS-1:0];
`endif

    always_ff @(posedge tx_pixel_clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_line     <= '0;
            r_pat      <= '0;
            r_const    <= '0;
            vsync      <= 1'b0;
            hsync      <= 1'b0;
            valid      <= 1'b0;
            data       <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef MIPI_FRAME_GEN_FRAME_CNT_EN
            r_frame_cnt <= '0;
`endif
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt_nxt;
            r_line     <= w_line_nxt;
            if (w_latch) begin
                r_pat   <= pattern_sel;
                r_const <= const_pix;
            end
            vsync      <= w_state != S_IDLE && w_state != S_FRAME_GAP;
            hsync      <= w_state == S_HS_PRE || w_state == S_ACTIVE || w_state == S_HS_POST;
            valid      <= w_state == S_ACTIVE;
            data       <= (w_state == S_ACTIVE) ? {4'd0, w_beat[PIX_PER_BEAT*PIX_BITS-1:PIX_BITS], w_p0} : 64'd0;
            busy       <= w_state != S_IDLE;
            frame_done <= w_fd;
`ifdef MIPI_FRAME_GEN_FRAME_CNT_EN
            if (w_fd) r_frame_cnt <= r_frame_cnt + 16'd1;
`endif
        end
    end
endmodule

// File: tb/tb_mipi_tx_frame_gen.sv
// tb_mipi_tx_frame_gen: directed self-checking bench for mipi_tx_frame_gen on a 12x2 frame
// (31-cycle period: vsync 0..25, line rows at 2..12 and 13..23, frame_done at 26).
module tb_mipi_tx_frame_gen;
    logic        tx_pixel_clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [9:0]  const_pix;
    logic        vsync, hsync, valid, busy, frame_done;
    logic [63:0] data;
`ifdef MIPI_FRAME_GEN_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_fcnt = 16'd0;

    always #5 tx_pixel_clk = ~tx_pixel_clk;

    mipi_tx_frame_gen #(
        .H_PIXELS(12), .V_LINES(2), .VS_LEAD(2), .HS_LEAD(3),
        .HS_TRAIL(2), .LINE_GAP(4), .VS_TRAIL(2), .FRAME_GAP(5)
    ) dut (
        .tx_pixel_clk (tx_pixel_clk),
        .rst          (rst),
        .enable       (enable),
        .pattern_sel  (pattern_sel),
        .const_pix    (const_pix),
        .vsync        (vsync),
        .hsync        (hsync),
        .valid        (valid),
        .data         (data),
        .busy         (busy),
        .frame_done   (frame_done)
`ifdef MIPI_FRAME_GEN_FRAME_CNT_EN
        ,
        .frame_cnt    (frame_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ctl"}, {59'd0, vsync, hsync, valid, busy, frame_done}, 64'd0);
        check({tag, "_data"}, data, 64'd0);
    endtask

    function automatic logic [9:0] mpix(input int pat, input int x, input int y, input logic [9:0] cp);
        case (pat)
            0:       return 10'(x % 1024);
            1:       return 10'(y % 1024);
            2:       return (((x >> 3) ^ (y >> 3)) & 1) != 0 ? 10'h3FF : 10'h000;
            default: return cp;
        endcase
    endfunction

    function automatic logic [63:0] exp_beat(input int pat, input logic [9:0] cp, input int b);
        logic [63:0] v = 64'd0;
        logic [9:0]  p;
        for (int k = 0; k < 6; k++) begin
            p = mpix(pat, (b % 2) * 6 + k, b / 2, cp);
`ifdef MIPI_FRAME_GEN_FRAME_CNT_EN
            if (b == 0 && k == 0) p = exp_fcnt[9:0];
`endif
            v[k*10 +: 10] = p;
        end
        return v;
    endfunction

    // Called on the negedge where vsync has just risen; returns on the negedge 31 cycles later.
    task automatic capture(input string tag, input int pat, input logic [9:0] cp,
                           input int chg_at, input logic chg_en, input logic [1:0] chg_pat);
        int vs_n = 0, hs_n = 0, va_n = 0, fd_n = 0, bz_n = 0, nz = 0, b = 0;
        int fd_at = -1, hs_first = -1, va_first = -1;
        for (int i = 0; i < 31; i++) begin
            if (vsync) vs_n++;
            if (busy) bz_n++;
            if (hsync) begin
                hs_n++;
                if (hs_first < 0) hs_first = i;
            end
            if (valid) begin
                if (va_first < 0) va_first = i;
                if (b == 0 && pat == 0) check({tag, "_beat0_lit"}, data, 64'h0014_0400_C020_0400);
                check($sformatf("%s_beat%0d", tag, b), data, exp_beat(pat, cp, b));
                va_n++;
                b++;
            end else if (data != 64'd0) nz++;
            if (frame_done) begin
                fd_n++;
                fd_at = i;
            end
            if (i == 26) exp_fcnt++;
            if (i == chg_at) begin
                enable      = chg_en;
                pattern_sel = chg_pat;
            end
            @(negedge tx_pixel_clk);
        end
        check({tag, "_vs_cycles"}, 64'(vs_n), 64'd26);
        check({tag, "_hs_cycles"}, 64'(hs_n), 64'd14);
        check({tag, "_valid_cycles"}, 64'(va_n), 64'd4);
        check({tag, "_busy_cycles"}, 64'(bz_n), 64'd31);
        check({tag, "_fd_count"}, 64'(fd_n), 64'd1);
        check({tag, "_fd_at"}, 64'(fd_at), 64'd26);
        check({tag, "_hs_first"}, 64'(hs_first), 64'd2);
        check({tag, "_valid_first"}, 64'(va_first), 64'd5);
        check({tag, "_data_idle_zero"}, 64'(nz), 64'd0);
`ifdef MIPI_FRAME_GEN_FRAME_CNT_EN
        check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_fcnt));
`endif
    endtask

    task automatic start(input string tag, input logic [1:0] pat, input logic [9:0] cp);
        enable      = 1'b1;
        pattern_sel = pat;
        const_pix   = cp;
        @(negedge tx_pixel_clk);
        check({tag, "_latency_vsync"}, 64'(vsync), 64'd1);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; pattern_sel = 2'd0; const_pix = 10'd0;
        @(negedge tx_pixel_clk);
        check_idle("reset");
`ifdef MIPI_FRAME_GEN_FRAME_CNT_EN
        check("reset_frame_cnt", 64'(frame_cnt), 64'd0);
`endif
        rst = 1'b0;
        @(negedge tx_pixel_clk);
        check_idle("post_reset");

        start("f1", 2'd0, 10'd0);
        capture("f1", 0, 10'd0, 0, 1'b0, 2'd0);
        check_idle("f1_end");

        start("f2", 2'd1, 10'd0);
        capture("f2", 1, 10'd0, 6, 1'b0, 2'd2);
        check_idle("f2_end");
        repeat (3) @(negedge tx_pixel_clk);
        check_idle("f2_stay_idle");

        start("f3", 2'd3, 10'h2A5);
        capture("f3", 3, 10'h2A5, 8, 1'b1, 2'd2);
        check("f3_b2b_vsync", 64'(vsync), 64'd1);
        capture("f4", 2, 10'h2A5, 0, 1'b0, 2'd2);
        check_idle("f4_end");

        start("f5", 2'd0, 10'd0);
        repeat (6) @(negedge tx_pixel_clk);
        check("f5_pre_rst_valid", 64'(valid), 64'd1);
        #1 rst = 1'b1;
        #1 check_idle("async_rst");
        exp_fcnt = 16'd0;
        @(negedge tx_pixel_clk);
        @(negedge tx_pixel_clk);
        rst = 1'b0;
        @(negedge tx_pixel_clk);
        check("restart_vsync", 64'(vsync), 64'd1);
        capture("f6", 0, 10'd0, 0, 1'b0, 2'd0);
        check_idle("f6_end");

`ifdef MIPI_FRAME_GEN_FRAME_CNT_EN
        rst = 1'b1;
        @(negedge tx_pixel_clk);
        rst = 1'b0;
        exp_fcnt = 16'd0;
        start("c1", 2'd3, 10'h2A5);
        capture("c1", 3, 10'h2A5, -1, 1'b1, 2'd3);
        check("c1_b2b_vsync", 64'(vsync), 64'd1);
        capture("c2", 3, 10'h2A5, -1, 1'b1, 2'd3);
        check("c2_b2b_vsync", 64'(vsync), 64'd1);
        capture("c3", 3, 10'h2A5, 0, 1'b0, 2'd3);
        check_idle("c3_end");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
